fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO, successor to the fixed 16-bit FIFO used across the design.
- Generic in data width, depth and almost-full/almost-empty thresholds.
- Exposes an occupancy count and pulse-type overflow/underflow error flags.
- Optional first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer datapath stages that share one clock.

Parameters:
WIDTH, 16, data word width in bits (≥1)
DEPTH, 8, number of storage words; power of two, ≥4
AF_LEVEL, DEPTH-2, almostfull asserted when count ≥ AF_LEVEL
AE_LEVEL, 2, almostempty asserted when count ≤ AE_LEVEL
AW (localparam), $clog2(DEPTH), pointer width; count is AW+1 bits

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
wr  in  1  write request
din  in  WIDTH  write data
rd  in  1  read request (FWFT: pop/acknowledge of head word)
dout  out  WIDTH  read data
valid  out  1  dout holds a valid word
count  out  AW+1  current occupancy, 0..DEPTH
almostfull  out  1  count ≥ AF_LEVEL
almostempty  out  1  count ≤ AE_LEVEL
full  out  1  count == DEPTH
empty  out  1  count == 0
over  out  1  one-cycle pulse: write rejected
under  out  1  one-cycle pulse: read rejected

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a clock edge) sets:
  - pointers and count to 0; dout to 0.
  - valid, over, under, full, almostfull to 0.
  - empty and almostempty to 1.
  - Reset overrides wr/rd in the same cycle. Reset mid-operation discards all contents.
- Write acceptance: wr && !full, evaluated on registered state at the edge. On accept, mem[wptr] <= din and wptr increments modulo DEPTH.
- Read acceptance (standard mode): rd && !empty. On accept, dout <= mem[rptr] and rptr increments. valid=1 in the next cycle only (latency 1); otherwise valid=0 and dout holds its value.
- Simultaneous wr and rd:
  - Each is judged independently against pre-edge flags.
  - When full: read accepted, write rejected, over=1, count becomes DEPTH-1.
  - When empty: write accepted, read rejected, under=1, count becomes 1.
  - Otherwise both are accepted and count is unchanged.
- over/under: registered, high for exactly one cycle after the rejected request, and never sticky.
- Flags are registered and consistent with count in the same cycle. count updates by +1 on write only, -1 on read only, 0 on both or neither.
- Pointers wrap silently at DEPTH. Full and empty are distinguished by count, not by pointer equality.
- Thresholds: AF_LEVEL > DEPTH or AE_LEVEL ≥ DEPTH are illegal and caught by an elaboration-time check that emits an error.

Optional Feature:
Macro FIFO_FWFT_EN.
- Defined:
  - The head word is presented on dout with valid=1 whenever the FIFO holds data, without any rd.
  - A word written into an empty FIFO at edge N is visible at dout/valid after edge N+1.
  - rd while valid=1 pops the head; the next word (if any) appears after the same edge.
  - rd while valid=0 gives under=1.
  - count includes the output-stage word.
- Undefined: standard mode as described above.

Decomposition:
- Shared package fifo_pkg:
  - function clog2.
  - Localparam defaults FIFO_DEF_WIDTH=16 and FIFO_DEF_DEPTH=8.
  - Threshold-check macro.
- One natural sub-module: fifo_ram, a WIDTH×DEPTH register-file memory with synchronous write and registered read port, reused by the FWFT output stage.

Test Plan:
All scenarios use WIDTH=16, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2.
1. After reset, write din=1..9 on 9 consecutive cycles.
   - almostempty drops at count 3; almostfull rises at count 6; full=1 at count 8.
   - The 9th write gives over=1 for one cycle; count stays 8.
2. From full, assert rd for 9 cycles.
   - dout=1..8 with valid=1 one cycle after each read.
   - The 9th read gives under=1 with valid=0; empty=1 and count=0.
3. Fill to 4 words, then hold wr=rd=1 for 10 cycles with an incrementing din.
   - count stays 4; output order is preserved.
4. Full, then wr=rd=1 in one cycle: read returns the oldest word, over=1, count=7.
5. Wrap-around: 3 rounds of 8 writes and 8 reads (24 words, values 0x0100+i). All 24 words are read back in order with no flag glitches.
6. Reset mid-operation: after 5 writes, pulse rst with wr=rd=1.
   - Next cycle: count=0, empty=1, valid=0.
   - A subsequent read gives under=1.
   - Under FIFO_FWFT_EN, repeat scenarios 1–2 expecting valid=1 and dout=1 one cycle after the first write.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults, helper function and parameter-legality check for the FIFO family.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Elaboration-time guard: DEPTH must be a power of two >= 4, AF_LEVEL <= DEPTH, AE_LEVEL < DEPTH.
`define FIFO_CHECK_PARAMS(DEPTH_P, AW_P, AF_P, AE_P) \
  if (((1 << (AW_P)) != (DEPTH_P)) || ((DEPTH_P) < 4) || ((AF_P) > (DEPTH_P)) || ((AE_P) >= (DEPTH_P))) begin : g_bad_params \
    $error("fifo_sync_param: illegal DEPTH/AF_LEVEL/AE_LEVEL combination"); \
  end

package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 16;
  localparam int FIFO_DEF_DEPTH = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH register-file memory: synchronous write, registered read port cleared by rst.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int  WIDTH = FIFO_DEF_WIDTH,
  parameter int  DEPTH = FIFO_DEF_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // registered read port; holds its value when not reading
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= {WIDTH{1'b0}};
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and over/under pulses.
// Define FIFO_FWFT_EN to build the first-word-fall-through read mode.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int  WIDTH    = FIFO_DEF_WIDTH,
  parameter int  DEPTH    = FIFO_DEF_DEPTH,
  parameter int  AF_LEVEL = DEPTH - 2,
  parameter int  AE_LEVEL = 2,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [AW:0]      count,
  output logic             almostfull,
  output logic             almostempty,
  output logic             full,
  output logic             empty,
  output logic             over,
  output logic             under
);

  `FIFO_CHECK_PARAMS(DEPTH, AW, AF_LEVEL, AE_LEVEL)

  localparam logic [AW:0]   DEPTH_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   AF_CNT    = AF_LEVEL[AW:0];
  localparam logic [AW:0]   AE_CNT    = AE_LEVEL[AW:0];
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic          wr_ok_s;
  logic          rd_ok_s;
  logic          re_s;
  logic          valid_nxt_s;
  logic [AW:0]   count_nxt_s;
`ifdef FIFO_FWFT_EN
  logic          ram_has_s;

  // words still in the array, i.e. not yet moved into the output stage
  assign ram_has_s = (count > {{AW{1'b0}}, valid});
`endif

  // request acceptance against pre-edge state, array read enable and next occupancy
  always_comb begin
    wr_ok_s     = wr && !full;
    count_nxt_s = count;
`ifdef FIFO_FWFT_EN
    rd_ok_s = rd && valid;
    re_s    = ram_has_s && (!valid || rd);
    if (re_s) begin
      valid_nxt_s = 1'b1;
    end else if (rd_ok_s) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid;
    end
`else
    rd_ok_s     = rd && !empty;
    re_s        = rd_ok_s;
    valid_nxt_s = rd_ok_s;
`endif
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count + CNT_ONE;
      2'b01:   count_nxt_s = count - CNT_ONE;
      default: count_nxt_s = count;
    endcase
  end

  // pointers, occupancy, status flags and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r      <= {AW{1'b0}};
      rptr_r      <= {AW{1'b0}};
      count       <= {(AW+1){1'b0}};
      valid       <= 1'b0;
      over        <= 1'b0;
      under       <= 1'b0;
      full        <= 1'b0;
      almostfull  <= 1'b0;
      empty       <= 1'b1;
      almostempty <= 1'b1;
    end else begin
      if (wr_ok_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (re_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      count       <= count_nxt_s;
      valid       <= valid_nxt_s;
      over        <= wr && !wr_ok_s;
      under       <= rd && !rd_ok_s;
      full        <= (count_nxt_s == DEPTH_CNT);
      empty       <= (count_nxt_s == {(AW+1){1'b0}});
      almostfull  <= (count_nxt_s >= AF_CNT);
      almostempty <= (count_nxt_s <= AE_CNT);
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok_s && !rst),
    .waddr (wptr_r),
    .wdata (din),
    .re    (re_s),
    .raddr (rptr_r),
    .rdata (dout)
  );

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: directed scenarios plus random traffic vs a queue model.
module tb_fifo_sync_param;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk;
  logic          rst;
  logic          wr;
  logic [W-1:0]  din;
  logic          rd;
  logic [W-1:0]  dout;
  logic          valid;
  logic [3:0]    count;
  logic          almostfull;
  logic          almostempty;
  logic          full;
  logic          empty;
  logic          over;
  logic          under;

  int n_checks;
  int n_errors;

  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  logic         m_valid;
  logic         m_over;
  logic         m_under;

  fifo_sync_param #(
    .WIDTH    (W),
    .DEPTH    (D),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr),
    .din         (din),
    .rd          (rd),
    .dout        (dout),
    .valid       (valid),
    .count       (count),
    .almostfull  (almostfull),
    .almostempty (almostempty),
    .full        (full),
    .empty       (empty),
    .over        (over),
    .under       (under)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: the FIFO is a queue; outputs follow from its size and the request rules.
  task automatic model_edge(input logic w, input logic [W-1:0] d, input logic r, input logic rs);
    int  pre_n;
    int  avail;
    bit  wok;
    bit  rok;
    if (rs) begin
      q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_over  = 1'b0;
      m_under = 1'b0;
    end else begin
      pre_n = q.size();
      wok   = w && (pre_n < D);
`ifdef FIFO_FWFT_EN
      rok = r && m_valid;
      if (rok) void'(q.pop_front());
      avail = q.size();
      if (wok) q.push_back(d);
      m_valid = (avail > 0);
      if (m_valid) m_dout = q[0];
`else
      rok   = r && (pre_n > 0);
      avail = 0;
      if (rok) m_dout = q.pop_front();
      m_valid = rok;
      if (wok) q.push_back(d);
`endif
      m_over  = w && !wok;
      m_under = r && !rok;
    end
  endtask

  task automatic compare_all();
    int sz;
    sz = q.size();
    chk("count", count, sz);
    chk("full", full, sz == D);
    chk("empty", empty, sz == 0);
    chk("almostfull", almostfull, sz >= AF);
    chk("almostempty", almostempty, sz <= AE);
    chk("valid", valid, m_valid);
    chk("dout", dout, m_dout);
    chk("over", over, m_over);
    chk("under", under, m_under);
  endtask

  task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic rs);
    wr  = w;
    din = d;
    rd  = r;
    rst = rs;
    @(posedge clk);
    model_edge(w, d, r, rs);
    #1;
    compare_all();
  endtask

  initial begin
    int bias;
    n_checks = 0;
    n_errors = 0;
    wr = 1'b0; rd = 1'b0; rst = 1'b0; din = '0;
    m_dout = '0; m_valid = 1'b0; m_over = 1'b0; m_under = 1'b0;

    // reset state
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // scenario 1: nine writes, last one overflows
    for (int i = 1; i <= 9; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    chk("s1_count", count, 32'd8);
    chk("s1_over", over, 32'd1);

    // scenario 2: nine reads, last one underflows
    for (int i = 1; i <= 9; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("s2_under", under, 32'd1);
    chk("s2_empty", empty, 32'd1);

    // scenario 3: four words then ten simultaneous read/write cycles
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0020 + W'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 16'h0030 + W'(i), 1'b1, 1'b0);

    // scenario 4: fill up, then read and write together
    for (int i = 0; (i < 16) && (q.size() < D); i++) step(1'b1, 16'h0040 + W'(i), 1'b0, 1'b0);
    step(1'b1, 16'h00ff, 1'b1, 1'b0);
    chk("s4_count", count, 32'd7);
    chk("s4_over", over, 32'd1);

    // scenario 5: wrap-around over three rounds
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) step(1'b1, 16'h0100 + W'(r * 8 + i), 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // scenario 6: reset mid-operation overrides wr/rd
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0200 + W'(i), 1'b0, 1'b0);
    step(1'b1, 16'h0aaa, 1'b1, 1'b1);
    chk("s6_count", count, 32'd0);
    chk("s6_valid", valid, 32'd0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("s6_under", under, 32'd1);

    // random traffic with varying fill pressure and occasional reset
    bias = 50;
    for (int i = 0; i < 800; i++) begin
      if ((i % 60) == 0) bias = 20 + 30 * int'($urandom_range(0, 2));
      step($urandom_range(0, 99) < bias, W'($urandom), $urandom_range(0, 99) < (100 - bias),
           $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
